// File: rtl/quick_spi_sequencer_if.sv
// Command, SPI-master and read-response signal bundle for quick_spi_sequencer.
// The master modport is the sequencer's view; the slave modport is the surrounding logic's view.
interface quick_spi_sequencer_if #(
    parameter int unsigned INCOMING_DATA_WIDTH = 8,
    parameter int unsigned OUTGOING_DATA_WIDTH = 16,
    parameter int unsigned NUMBER_OF_SLAVES    = 2
);
    logic                           cmd_valid;
    logic                           cmd_ready;
    logic [NUMBER_OF_SLAVES-1:0]    cmd_slave;
    logic                           cmd_operation;
    logic [OUTGOING_DATA_WIDTH-1:0] cmd_data;

    logic                           spi_enable;
    logic                           spi_start_transaction;
    logic [NUMBER_OF_SLAVES-1:0]    spi_slave;
    logic                           spi_operation;
    logic [OUTGOING_DATA_WIDTH-1:0] spi_outgoing_data;
    logic                           spi_end_of_transaction;
    logic [INCOMING_DATA_WIDTH-1:0] spi_incoming_data;

    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [INCOMING_DATA_WIDTH-1:0] rsp_data;
    logic [NUMBER_OF_SLAVES-1:0]    rsp_slave;

    modport master (
        input  cmd_valid, cmd_slave, cmd_operation, cmd_data,
               spi_end_of_transaction, spi_incoming_data, rsp_ready,
        output cmd_ready, spi_enable, spi_start_transaction, spi_slave,
               spi_operation, spi_outgoing_data, rsp_valid, rsp_data, rsp_slave
    );

    modport slave (
        output cmd_valid, cmd_slave, cmd_operation, cmd_data,
               spi_end_of_transaction, spi_incoming_data, rsp_ready,
        input  cmd_ready, spi_enable, spi_start_transaction, spi_slave,
               spi_operation, spi_outgoing_data, rsp_valid, rsp_data, rsp_slave
    );
endinterface

// File: rtl/quick_spi_sequencer.sv
// Queues SPI commands in a small FIFO and issues them one at a time to an SPI master,
// enforcing a completion timeout, an inter-transaction gap and a single held read response.
module quick_spi_sequencer #(
    parameter int unsigned INCOMING_DATA_WIDTH = 8,
    parameter int unsigned OUTGOING_DATA_WIDTH = 16,
    parameter int unsigned NUMBER_OF_SLAVES    = 2,
    parameter int unsigned FIFO_DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES      = 1024,
    parameter int unsigned GAP_CYCLES          = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    quick_spi_sequencer_if.master         bus,
    output logic                          busy,
    output logic                          timeout_err,
    output logic                          bad_slave_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = NUMBER_OF_SLAVES;
    localparam int unsigned OW = OUTGOING_DATA_WIDTH;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

    state_t        state, state_nx;
    logic [SW-1:0] mem_slave [FIFO_DEPTH];
    logic          mem_op    [FIFO_DEPTH];
    logic [OW-1:0] mem_data  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] tcnt, tcnt_nx;
    logic [GW-1:0] gcnt, gcnt_nx;
    logic [CW-1:0] count_nx;
    logic          push, pop, latch, capture, rsp_clear, timeout_nx, bad_nx, head_bad;

    // Next-state, FIFO pop and event decisions
    always_comb begin
        state_nx   = state;
        tcnt_nx    = tcnt;
        gcnt_nx    = gcnt;
        pop        = 1'b0;
        latch      = 1'b0;
        capture    = 1'b0;
        timeout_nx = 1'b0;
        bad_nx     = 1'b0;
        push       = bus.cmd_valid && bus.cmd_ready;
        rsp_clear  = bus.rsp_valid && bus.rsp_ready;
        head_bad   = 32'(mem_slave[rd_ptr]) >= NUMBER_OF_SLAVES;

        case (state)
            IDLE: begin
                // A read must not be issued while an earlier response is still held
                if (fifo_count != '0 && (mem_op[rd_ptr] || !bus.rsp_valid)) begin
                    pop = 1'b1;
                    if (head_bad) begin
                        bad_nx = 1'b1;
                    end else begin
                        latch    = 1'b1;
                        state_nx = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_nx = BUSY;
                tcnt_nx  = '0;
            end
            BUSY: begin
                // Completion wins over a timeout landing on the same cycle
                if (bus.spi_end_of_transaction) begin
                    state_nx = GAP;
                    gcnt_nx  = '0;
                    capture  = !bus.spi_operation;
                end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_nx   = GAP;
                    gcnt_nx    = '0;
                    timeout_nx = 1'b1;
                end else begin
                    tcnt_nx = tcnt + 1'b1;
                end
            end
            GAP: begin
                if (gcnt == GW'(GAP_CYCLES - 1)) begin
                    state_nx = IDLE;
                end else begin
                    gcnt_nx = gcnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        count_nx = fifo_count + CW'(push) - CW'(pop);
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push) begin
            mem_slave[wr_ptr] <= bus.cmd_slave;
            mem_op[wr_ptr]    <= bus.cmd_operation;
            mem_data[wr_ptr]  <= bus.cmd_data;
        end
    end

    // State, pointers and all registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                     <= IDLE;
            tcnt                      <= '0;
            gcnt                      <= '0;
            wr_ptr                    <= '0;
            rd_ptr                    <= '0;
            fifo_count                <= '0;
            bus.cmd_ready             <= 1'b0;
            bus.spi_enable            <= 1'b0;
            bus.spi_start_transaction <= 1'b0;
            bus.spi_slave             <= '0;
            bus.spi_operation         <= 1'b0;
            bus.spi_outgoing_data     <= '0;
            bus.rsp_valid             <= 1'b0;
            bus.rsp_data              <= '0;
            bus.rsp_slave             <= '0;
            busy                      <= 1'b0;
            timeout_err               <= 1'b0;
            bad_slave_err             <= 1'b0;
        end else begin
            state                     <= state_nx;
            tcnt                      <= tcnt_nx;
            gcnt                      <= gcnt_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count                <= count_nx;
            bus.cmd_ready             <= count_nx < CW'(FIFO_DEPTH);
            bus.spi_enable            <= 1'b1;
            bus.spi_start_transaction <= (state_nx == ISSUE);
            if (latch) begin
                bus.spi_slave         <= mem_slave[rd_ptr];
                bus.spi_operation     <= mem_op[rd_ptr];
                bus.spi_outgoing_data <= mem_data[rd_ptr];
            end
            if (capture) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= bus.spi_incoming_data;
                bus.rsp_slave <= bus.spi_slave;
            end else if (rsp_clear) begin
                bus.rsp_valid <= 1'b0;
            end
            busy                      <= (state_nx != IDLE) || (count_nx != '0);
            timeout_err               <= timeout_nx;
            bad_slave_err             <= bad_nx;
        end
    end
endmodule

// File: tb/tb_quick_spi_sequencer.sv
// Directed bench for quick_spi_sequencer: a timeline/queue model checked every cycle,
// plus literal expectations for the key latencies and values of each scenario.
module tb_quick_spi_sequencer;
    localparam int unsigned IW    = 8;
    localparam int unsigned OW    = 16;
    localparam int unsigned NS    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 1024;
    localparam int unsigned GAP   = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          busy, timeout_err, bad_slave_err;
    logic [CW-1:0] fifo_count;
    int            checks = 0;
    int            errors = 0;

    quick_spi_sequencer_if #(.INCOMING_DATA_WIDTH(IW), .OUTGOING_DATA_WIDTH(OW),
                             .NUMBER_OF_SLAVES(NS)) bus ();

    quick_spi_sequencer #(
        .INCOMING_DATA_WIDTH(IW), .OUTGOING_DATA_WIDTH(OW), .NUMBER_OF_SLAVES(NS),
        .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus), .busy(busy),
        .timeout_err(timeout_err), .bad_slave_err(bad_slave_err), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // SPI master stand-in: answers each start pulse resp_lat cycles later, unless told not to
    int         resp_lat   = 2;
    logic [7:0] resp_data  = 8'h00;
    bit         resp_never = 1'b0;
    initial begin
        bus.spi_end_of_transaction = 1'b0;
        bus.spi_incoming_data      = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.spi_start_transaction === 1'b1 && !resp_never) begin
                repeat (resp_lat) @(posedge clk);
                #2;
                bus.spi_end_of_transaction = 1'b1;
                bus.spi_incoming_data      = resp_data;
                @(posedge clk); #2;
                bus.spi_end_of_transaction = 1'b0;
                bus.spi_incoming_data      = '0;
            end
        end
    end

    // Model: command queue plus edge-number timeline of the single in-flight transaction
    typedef struct { logic [1:0] slave; logic op; logic [15:0] data; } cmd_t;
    cmd_t       q[$];
    int         edge_n     = 0;
    bit         seen_reset = 1'b0;
    bit         m_inflight = 1'b0;
    int         m_pop_edge = 0;
    int         m_idle_edge = 0;
    logic [1:0] m_slave = '0;
    logic       m_op = 1'b0;
    logic [15:0] m_data = '0;
    bit         m_rsp_valid = 1'b0;
    logic [7:0] m_rsp_data = '0;
    logic [1:0] m_rsp_slave = '0;
    bit         m_cmd_ready = 1'b0, m_enable = 1'b0, m_start = 1'b0, m_busy = 1'b0;
    bit         m_tmo = 1'b0, m_bad = 1'b0;

    always begin : model_p
        cmd_t c;
        bit   old_rv;
        @(posedge clk);
        edge_n++;
        if (!reset_n) begin
            q.delete();
            seen_reset  = 1'b1;
            m_inflight  = 1'b0;
            m_idle_edge = edge_n;
            m_slave = '0; m_op = 1'b0; m_data = '0;
            m_rsp_valid = 1'b0; m_rsp_data = '0; m_rsp_slave = '0;
            m_cmd_ready = 1'b0; m_enable = 1'b0; m_start = 1'b0;
            m_busy = 1'b0; m_tmo = 1'b0; m_bad = 1'b0;
        end else begin
            old_rv  = m_rsp_valid;
            m_start = 1'b0; m_tmo = 1'b0; m_bad = 1'b0; m_enable = 1'b1;
            if (m_rsp_valid && bus.rsp_ready) m_rsp_valid = 1'b0;
            // End-of-transaction only counts once the start pulse has gone by
            if (m_inflight && edge_n >= m_pop_edge + 2) begin
                if (bus.spi_end_of_transaction) begin
                    m_inflight  = 1'b0;
                    m_idle_edge = edge_n + GAP;
                    if (!m_op) begin
                        m_rsp_valid = 1'b1;
                        m_rsp_data  = bus.spi_incoming_data;
                        m_rsp_slave = m_slave;
                    end
                end else if (edge_n == m_pop_edge + 1 + TMO) begin
                    m_inflight  = 1'b0;
                    m_idle_edge = edge_n + GAP;
                    m_tmo       = 1'b1;
                end
            end
            if (!m_inflight && edge_n > m_idle_edge && q.size() > 0 && (q[0].op || !old_rv)) begin
                c = q.pop_front();
                if (c.slave >= 2'd2) begin
                    m_bad = 1'b1;
                end else begin
                    m_inflight = 1'b1;
                    m_pop_edge = edge_n;
                    m_slave = c.slave; m_op = c.op; m_data = c.data;
                    m_start = 1'b1;
                end
            end
            if (bus.cmd_valid && m_cmd_ready) begin
                c.slave = bus.cmd_slave; c.op = bus.cmd_operation; c.data = bus.cmd_data;
                q.push_back(c);
            end
            m_cmd_ready = q.size() < DEPTH;
            m_busy      = m_inflight || edge_n < m_idle_edge || q.size() != 0;
        end
        #1;
        if (seen_reset) begin
            chk("cmd_ready", bus.cmd_ready, m_cmd_ready);
            chk("fifo_count", fifo_count, q.size());
            chk("spi_enable", bus.spi_enable, m_enable);
            chk("spi_start", bus.spi_start_transaction, m_start);
            chk("spi_slave", bus.spi_slave, m_slave);
            chk("spi_operation", bus.spi_operation, m_op);
            chk("spi_outgoing_data", bus.spi_outgoing_data, m_data);
            chk("rsp_valid", bus.rsp_valid, m_rsp_valid);
            chk("rsp_data", bus.rsp_data, m_rsp_data);
            chk("rsp_slave", bus.rsp_slave, m_rsp_slave);
            chk("busy", busy, m_busy);
            chk("timeout_err", timeout_err, m_tmo);
            chk("bad_slave_err", bad_slave_err, m_bad);
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic push(input logic [1:0] s, input logic op, input logic [15:0] d, output bit ok);
        int b;
        b  = 0;
        ok = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_slave = s; bus.cmd_operation = op; bus.cmd_data = d;
        while (!ok && b < 2000) begin
            ok = (bus.cmd_ready === 1'b1);
            tick();
            b++;
        end
        bus.cmd_valid = 1'b0;
        if (!ok) chk("push_accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_busy_low(input int budget, output int n);
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int starts;
        bit ok;
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_slave = '0; bus.cmd_operation = 1'b0;
        bus.cmd_data = '0; bus.rsp_ready = 1'b0;
        repeat (3) tick();
        chk("reset_cmd_ready", bus.cmd_ready, 0);
        chk("reset_spi_enable", bus.spi_enable, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fifo_count", fifo_count, 0);
        reset_n = 1'b1;
        tick();
        chk("first_edge_cmd_ready", bus.cmd_ready, 1);
        chk("first_edge_spi_enable", bus.spi_enable, 1);

        // Write: start pulse in the second cycle, no response, busy drops after the gap
        resp_lat = 3;
        push(2'd1, 1'b1, 16'hA55A, ok);
        chk("wr_start_cycle1", bus.spi_start_transaction, 0);
        tick();
        chk("wr_start_cycle2", bus.spi_start_transaction, 1);
        chk("wr_slave", bus.spi_slave, 1);
        chk("wr_op", bus.spi_operation, 1);
        chk("wr_data", bus.spi_outgoing_data, 16'hA55A);
        wait_busy_low(50, n);
        chk("wr_busy_cycles", 1 + n, 7);
        chk("wr_no_rsp", bus.rsp_valid, 0);

        // Read: response captured from the eot cycle, then consumed
        resp_lat = 2; resp_data = 8'h3C;
        push(2'd0, 1'b0, 16'h0042, ok);
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 50) begin tick(); n++; end
        chk("rd_latency", n, 4);
        chk("rd_data", bus.rsp_data, 8'h3C);
        chk("rd_slave", bus.rsp_slave, 0);
        bus.rsp_ready = 1'b1;
        tick();
        chk("rd_consumed", bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;
        wait_busy_low(50, n);

        // Backpressure: held response stalls queued reads until consumed
        resp_lat = 1; resp_data = 8'h5A;
        push(2'd1, 1'b0, 16'h0001, ok);
        wait_busy_low(50, n);
        chk("bp_rsp_held", bus.rsp_valid, 1);
        push(2'd0, 1'b0, 16'h0010, ok);
        push(2'd1, 1'b0, 16'h0020, ok);
        push(2'd0, 1'b0, 16'h0030, ok);
        push(2'd1, 1'b0, 16'h0040, ok);
        chk("bp_ready_full", bus.cmd_ready, 0);
        chk("bp_count_full", fifo_count, 4);
        repeat (3) tick();
        chk("bp_stall_count", fifo_count, 4);
        chk("bp_stall_busy", busy, 1);
        bus.rsp_ready = 1'b1;
        push(2'd0, 1'b1, 16'hBEEF, ok);
        chk("bp_push5", 32'(ok), 1);
        wait_busy_low(300, n);
        chk("bp_drained_busy", busy, 0);
        chk("bp_drained_count", fifo_count, 0);
        chk("bp_drained_rsp", bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;

        // Bad slave index: error pulse, no SPI activity
        push(2'd2, 1'b1, 16'h1111, ok);
        chk("bad_early", bad_slave_err, 0);
        tick();
        chk("bad_pulse", bad_slave_err, 1);
        chk("bad_no_start", bus.spi_start_transaction, 0);
        chk("bad_idle", busy, 0);
        tick();
        chk("bad_clear", bad_slave_err, 0);

        // Timeout after 1024 BUSY cycles, then the queued command issues
        resp_never = 1'b1;
        push(2'd0, 1'b1, 16'h0F0F, ok);
        push(2'd1, 1'b1, 16'h7777, ok);
        n = 1;
        while (timeout_err !== 1'b1 && n < 1100) begin tick(); n++; end
        chk("tmo_cycle", n, 1026);
        resp_never = 1'b0; resp_lat = 1;
        while (bus.spi_start_transaction !== 1'b1 && n < 1100) begin tick(); n++; end
        chk("tmo_next_issue", n, 1029);
        chk("tmo_next_data", bus.spi_outgoing_data, 16'h7777);
        wait_busy_low(50, n);

        // Reset mid-BUSY with three commands queued
        resp_never = 1'b1;
        push(2'd0, 1'b1, 16'h0001, ok);
        push(2'd1, 1'b1, 16'h0002, ok);
        push(2'd0, 1'b0, 16'h0003, ok);
        push(2'd1, 1'b1, 16'h0004, ok);
        chk("rst_queued", fifo_count, 3);
        chk("rst_busy_before", busy, 1);
        reset_n = 1'b0;
        tick();
        chk("rst_count", fifo_count, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_enable", bus.spi_enable, 0);
        chk("rst_start", bus.spi_start_transaction, 0);
        chk("rst_slave", bus.spi_slave, 0);
        chk("rst_data", bus.spi_outgoing_data, 0);
        chk("rst_busy", busy, 0);
        tick();
        reset_n = 1'b1;
        starts = 0;
        repeat (20) begin
            tick();
            if (bus.spi_start_transaction === 1'b1) starts++;
        end
        chk("rst_no_start", starts, 0);
        chk("rst_idle", busy, 0);
        chk("rst_ready_again", bus.cmd_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/quick_spi_sequencer.md
QUICK_SPI_SEQUENCER -- requirements
Module: quick_spi_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- INCOMING_DATA_WIDTH, 8, read-data width returned by the SPI master.
- OUTGOING_DATA_WIDTH, 16, outgoing command/data word width.
- NUMBER_OF_SLAVES, 2, number of chip selects; also the width of the slave index fields.
- FIFO_DEPTH, 4, command FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 1024, maximum BUSY cycles allowed before a timeout.
- GAP_CYCLES, 2, idle cycles enforced between transactions; minimum 1.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic is on the rising edge.
- reset_n, in, 1, synchronous, active-low reset.
- cmd_valid, in, 1, command offered.
- cmd_ready, out, 1, command FIFO can accept a command.
- cmd_slave, in, NUMBER_OF_SLAVES, binary slave index.
- cmd_operation, in, 1, 0 = read, 1 = write.
- cmd_data, in, OUTGOING_DATA_WIDTH, outgoing word.
- spi_enable, out, 1, enable to the SPI master.
- spi_start_transaction, out, 1, one-cycle start pulse.
- spi_slave, out, NUMBER_OF_SLAVES, slave index to the master.
- spi_operation, out, 1, operation to the master.
- spi_outgoing_data, out, OUTGOING_DATA_WIDTH, word to the master.
- spi_end_of_transaction, in, 1, one-cycle completion pulse from the master.
- spi_incoming_data, in, INCOMING_DATA_WIDTH, read data; valid only in the end_of_transaction cycle.
- rsp_valid, out, 1, read response held.
- rsp_ready, in, 1, response consumed.
- rsp_data, out, INCOMING_DATA_WIDTH, captured read data.
- rsp_slave, out, NUMBER_OF_SLAVES, slave index the response came from.
- busy, out, 1, state is not IDLE or the FIFO is non-empty.
- timeout_err, out, 1, one-cycle pulse.
- bad_slave_err, out, 1, one-cycle pulse.
- fifo_count, out, $clog2(FIFO_DEPTH)+1, number of occupied FIFO entries.

Function
REQ-003 A command SHALL be pushed on any edge where cmd_valid and cmd_ready are both 1; cmd_ready SHALL be 1 exactly when fifo_count < FIFO_DEPTH.
REQ-004 The FIFO SHALL be first-in first-out with wrapping pointers; a simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-005 The state machine SHALL have four states: IDLE, ISSUE, BUSY, GAP.
REQ-006 In IDLE, the head entry SHALL be popped when the FIFO is non-empty and either the head is a write or rsp_valid is 0; a head read with rsp_valid=1 SHALL stall in IDLE.
REQ-007 A popped entry with slave index >= NUMBER_OF_SLAVES SHALL be discarded: bad_slave_err pulses for one cycle, there is no SPI activity, and the state stays IDLE.
REQ-008 A valid popped entry SHALL be latched into spi_slave, spi_operation and spi_outgoing_data, and the state SHALL move to ISSUE.
REQ-009 In ISSUE, spi_start_transaction SHALL be 1 for exactly that one cycle; the next state SHALL be BUSY.
REQ-010 For a command pushed into an empty FIFO while IDLE, spi_start_transaction SHALL be high in the second cycle after the accepting edge.
REQ-011 spi_slave, spi_operation and spi_outgoing_data SHALL hold constant from ISSUE through the end of BUSY.
REQ-012 In BUSY, a timeout counter SHALL increment each cycle. On spi_end_of_transaction=1, the state SHALL move to GAP, and a read SHALL also load rsp_data from spi_incoming_data, rsp_slave from spi_slave, and set rsp_valid to 1.
REQ-013 If the counter reaches TIMEOUT_CYCLES without spi_end_of_transaction, timeout_err SHALL pulse for one cycle, the state SHALL move to GAP, and no response SHALL be produced.
REQ-014 end_of_transaction arriving in the same cycle as the timeout SHALL take priority: the transaction completes normally and there is no timeout_err.
REQ-015 GAP SHALL last exactly GAP_CYCLES cycles and then return to IDLE; spi_end_of_transaction seen outside BUSY SHALL be ignored.
REQ-016 rsp_valid SHALL clear on an edge where rsp_valid and rsp_ready are both 1; rsp_data and rsp_slave SHALL hold until the next capture.
REQ-017 A capture SHALL never coincide with rsp_valid=1, because REQ-006 guarantees this.
REQ-018 spi_enable SHALL be 1 in every cycle that reset_n is 1.
REQ-019 busy SHALL be 0 only when the state is IDLE and fifo_count = 0.

Reset
REQ-020 While reset_n=0 at an edge, the block SHALL set:
- state = IDLE, FIFO empty, fifo_count = 0, cmd_ready = 0;
- spi_enable = 0, spi_start_transaction = 0, spi_slave = 0, spi_operation = 0, spi_outgoing_data = 0;
- rsp_valid = 0, rsp_data = 0, rsp_slave = 0;
- busy = 0, timeout_err = 0, bad_slave_err = 0.
REQ-021 Reset asserted mid-transaction SHALL abandon that transaction and discard all queued commands; no response SHALL be produced for them.
REQ-022 cmd_ready SHALL go to 1 on the first edge with reset_n=1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write: push slave=1, op=1, data=16'hA55A into an empty FIFO -> start pulse 2 cycles later with fields 1/1/A55A; eot -> no rsp_valid; GAP for 2 cycles; busy drops.
- Read: push slave=0, op=0; model returns 8'h3C with eot -> rsp_valid=1, rsp_data=3C, rsp_slave=0; rsp_ready=1 -> rsp_valid=0.
- Backpressure: push 5 commands back to back, FIFO_DEPTH=4 -> cmd_ready=0 after the 4th; a read behind an unconsumed response stalls in IDLE until rsp_ready.
- Bad slave and timeout: push slave=2 -> bad_slave_err pulse, no start pulse; a model that never returns eot -> timeout_err pulses on the 1024th BUSY cycle, then the next command issues.
- Reset mid-BUSY with 3 commands queued -> all outputs at reset values, fifo_count=0, no start pulse after reset_n rises.
